rgb2hsv_pipe: RTL and testbench
===============================

// Module: rgb2hsv_pipe
// PURPOSE
//  Pipelined RGB888 -> packed-HSV converter feeding the green-screen keyer.
//  Produces hue 0..359 in [23:15], saturation 0..100 in [14:8] and value 0..255 in [7:0].
//  One pixel per clock, fixed latency. Row/col and sideband data are delayed to stay aligned.
// PARAMETERS
//  SB_W     24   width of pass_in/pass_thru sideband (carries raw RGB for later stages)
//  LATENCY  10   fixed in->out delay in cycles; a derived constant, not tunable
// PORTS
//  clk        in   1      pixel clock; single clock domain
//  rst        in   1      synchronous, active-high reset
//  ce         in   1      pipeline clock enable; 0 = every stage holds
//  hsv_en     in   1      1 = convert; 0 = RGB bypass at same latency
//  in_valid   in   1      pixel_in/row/col/pass_in qualify this cycle
//  row        in   13     pixel row coordinate
//  col        in   13     pixel column coordinate
//  pixel_in   in   24     {R[23:16], G[15:8], B[7:0]}
//  pass_in    in   SB_W   sideband, delayed untouched
//  out_valid  out  1      pixel_out/row_out/col_out/pass_thru qualify
//  row_out    out  13     row, delayed LATENCY
//  col_out    out  13     col, delayed LATENCY
//  pixel_out  out  24     {H[23:15], S[14:8], V[7:0]}, or RGB when bypassed
//  pass_thru  out  SB_W   pass_in, delayed LATENCY
// BEHAVIOUR
//  - Reset: all valid bits clear; every output register = 0, including out_valid.
//  - Reset wins over ce. Pixels in flight at reset are dropped, not flushed.
//  - No backpressure. With ce=1, output at cycle t+10 corresponds to input at t.
//    ce=0 freezes all stages; a ce=0 cycle does not count toward latency.
//  - hsv_en is sampled with the pixel in S1 and travels in the pipe,
//    so toggling it mid-frame affects only later pixels.
//  - Data registers advance even when valid=0. Downstream must qualify on out_valid.
//  - S1: register inputs. max = max(R,G,B); min = min(R,G,B).
//    Tie priority for the max channel: R > G > B.
//  - S2: delta = max - min.
//    Hue numerator = 60*|d| (14b), where d = G-B if max=R, B-R if max=G, R-G if max=B.
//    Keep the sign of d and a base of 0/120/240.
//    Saturation numerator = 100*delta (15b).
//  - S3..S9: two lanes of div_pipe, 7 quotient bits, one bit per stage.
//    Both divide unsigned and truncate.
//    Hue lane: divisor = delta, quotient <= 60.
//    Saturation lane: divisor = max, quotient <= 100.
//  - S10: h = base + q if d >= 0, base - q if d < 0; add 360 if the result is negative.
//    Result is always in 0..359.
//  - S10 zero cases: delta = 0 forces H = 0. max = 0 forces S = 0.
//    A zero divisor never reaches the output.
//  - V = max. All arithmetic is sized explicitly; no truncation before the final 9/7/8-bit pack.
// STRUCTURE
//  - Package hsv_pkg holds:
//    the field widths HUE_W=9, SAT_W=7, VAL_W=8;
//    the field slice localparams for [23:15], [14:8], [7:0];
//    HUE_MAX=360 and SAT_MAX=100;
//    RGB2HSV_LATENCY=10.
//    The keyer and the later HSV->RGB stage share this package.
//  - Sub-module div_pipe: parameters NUM_W, DEN_W, Q_W. Restoring divider with one bit per stage.
//    ce and rst are passed through. Instantiate it twice.
// TESTING
//  - (255,0,0) -> {9'd0, 7'd100, 8'd255} exactly 10 cycles later, with out_valid high.
//  - (0,255,0) -> H=120, S=100, V=255. (0,0,255) -> H=240, S=100, V=255. (0,200,0) -> H=120, S=100, V=200.
//  - (255,0,128): d = -128, q = 30 -> H=330, S=100, V=255.
//    (100,200,150) -> H=150, S=50, V=200.
//  - (128,128,128) -> 0x000080, with H and S both 0. (0,0,0) -> 0x000000.
//    No X at the outputs for either input.
//  - Back-to-back stream of 1000 random pixels with random in_valid gaps and ce low
//    for random cycles. Compare against a golden model. Row, col and pass_thru stay aligned.
//  - Assert rst mid-stream -> out_valid=0 and all outputs 0 on the next edge.
//    The first post-reset pixel emerges after 10 ce cycles.
//    hsv_en=0 -> pixel_out equals pixel_in at 10 cycles.

Source files
------------

// File: rtl/hsv_pkg.sv
// Shared HSV field layout and limits for the RGB->HSV converter, keyer and HSV->RGB stage.
package hsv_pkg;
  localparam int HUE_W = 9;
  localparam int SAT_W = 7;
  localparam int VAL_W = 8;

  localparam int HUE_HI = 23;
  localparam int HUE_LO = 15;
  localparam int SAT_HI = 14;
  localparam int SAT_LO = 8;
  localparam int VAL_HI = 7;
  localparam int VAL_LO = 0;

  localparam int HUE_MAX    = 360;
  localparam int SAT_MAX    = 100;
  localparam int HUE_SECTOR = 60;
  localparam int HUE_BASE_G = 120;
  localparam int HUE_BASE_B = 240;

  localparam int RGB2HSV_LATENCY = 10;
endpackage

// File: rtl/div_pipe.sv
// Pipelined unsigned restoring divider: one quotient bit resolved per stage, truncating.
module div_pipe #(
  parameter int NUM_W = 14,
  parameter int DEN_W = 8,
  parameter int Q_W   = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic             in_vld,
  input  logic [NUM_W-1:0] num,
  input  logic [DEN_W-1:0] den,
  output logic             out_vld,
  output logic [Q_W-1:0]   quo
);
  localparam int CW = NUM_W + DEN_W;

  logic [CW-1:0]    rem_p [Q_W];
  logic [DEN_W-1:0] den_p [Q_W];
  logic [Q_W-1:0]   quo_p [Q_W];
  logic [Q_W-1:0]   vld_p;

  logic [CW-1:0]    rem_in [Q_W];
  logic [DEN_W-1:0] den_in [Q_W];
  logic [Q_W-1:0]   quo_in [Q_W];
  logic [CW-1:0]    trial  [Q_W];

  always_comb begin
    rem_in[0] = CW'(num);
    den_in[0] = den;
    quo_in[0] = '0;
    for (int k = 1; k < Q_W; k++) begin
      rem_in[k] = rem_p[k-1];
      den_in[k] = den_p[k-1];
      quo_in[k] = quo_p[k-1];
    end
    for (int k = 0; k < Q_W; k++) begin
      trial[k] = CW'(den_in[k]) << (Q_W - 1 - k);
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      vld_p <= '0;
    else if (ce)
      vld_p <= {vld_p[Q_W-2:0], in_vld};
  end

  // stage k resolves quotient bit Q_W-1-k
  always_ff @(posedge clk) begin
    if (ce) begin
      for (int k = 0; k < Q_W; k++) begin
        if (rem_in[k] >= trial[k]) begin
          rem_p[k] <= rem_in[k] - trial[k];
          quo_p[k] <= quo_in[k] | (Q_W'(1) << (Q_W - 1 - k));
        end else begin
          rem_p[k] <= rem_in[k];
          quo_p[k] <= quo_in[k];
        end
        den_p[k] <= den_in[k];
      end
    end
  end

  assign out_vld = vld_p[Q_W-1];
  assign quo     = quo_p[Q_W-1];
endmodule

// File: rtl/rgb2hsv_pipe.sv
// RGB888 -> packed HSV {H9,S7,V8}, one pixel per clock, fixed 10-cycle latency.
module rgb2hsv_pipe
  import hsv_pkg::*;
#(
  parameter int SB_W = 24
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ce,
  input  logic            hsv_en,
  input  logic            in_valid,
  input  logic [12:0]     row,
  input  logic [12:0]     col,
  input  logic [23:0]     pixel_in,
  input  logic [SB_W-1:0] pass_in,
  output logic            out_valid,
  output logic [12:0]     row_out,
  output logic [12:0]     col_out,
  output logic [23:0]     pixel_out,
  output logic [SB_W-1:0] pass_thru
);
  localparam int LATENCY = RGB2HSV_LATENCY;
  localparam int DQ_W    = LATENCY - 3;
  localparam int HNUM_W  = 14;
  localparam int SNUM_W  = 15;
  localparam int COL_LO  = SB_W;
  localparam int ROW_LO  = SB_W + 13;
  localparam int RGB_LO  = SB_W + 26;
  localparam int SIDE_W  = SB_W + 51;
  localparam int AUX_W   = HUE_W + 1 + VAL_W + 1;

  function automatic logic [VAL_W-1:0] mag8(input logic signed [8:0] d);
    logic signed [8:0] a;
    a = d[8] ? -d : d;
    return a[VAL_W-1:0];
  endfunction

  function automatic logic [HUE_W-1:0] hue_fold(input logic [HUE_W-1:0] base,
                                                input logic neg,
                                                input logic [DQ_W-1:0] q);
    logic signed [HUE_W+1:0] h;
    if (neg)
      h = $signed({2'b00, base}) - $signed((HUE_W+2)'(q));
    else
      h = $signed({2'b00, base}) + $signed((HUE_W+2)'(q));
    if (h < 0)
      h = h + $signed((HUE_W+2)'(HUE_MAX));
    return h[HUE_W-1:0];
  endfunction

  // S1..S9 sideband: {hsv_en, rgb, row, col, pass}
  logic [SIDE_W-1:0] side_p [LATENCY-1];
  logic              vld_p1;

  always_ff @(posedge clk) begin
    if (ce) begin
      side_p[0] <= {hsv_en, pixel_in, row, col, pass_in};
      for (int k = 1; k < LATENCY - 1; k++)
        side_p[k] <= side_p[k-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      vld_p1 <= 1'b0;
    else if (ce)
      vld_p1 <= in_valid;
  end

  // S1 -> S2: max/min, signed hue difference and sector base
  logic [VAL_W-1:0] r_p1, g_p1, b_p1, max_c, min_c, dlt_c;
  logic signed [8:0] d_c;
  logic [HUE_W-1:0]  base_c;

  assign r_p1 = side_p[0][RGB_LO+16 +: 8];
  assign g_p1 = side_p[0][RGB_LO+8  +: 8];
  assign b_p1 = side_p[0][RGB_LO    +: 8];

  always_comb begin
    max_c  = r_p1;
    min_c  = r_p1;
    d_c    = '0;
    base_c = '0;
    if (r_p1 >= g_p1 && r_p1 >= b_p1) begin
      max_c  = r_p1;
      min_c  = (g_p1 < b_p1) ? g_p1 : b_p1;
      d_c    = $signed({1'b0, g_p1}) - $signed({1'b0, b_p1});
      base_c = '0;
    end else if (g_p1 >= b_p1) begin
      max_c  = g_p1;
      min_c  = (r_p1 < b_p1) ? r_p1 : b_p1;
      d_c    = $signed({1'b0, b_p1}) - $signed({1'b0, r_p1});
      base_c = HUE_W'(HUE_BASE_G);
    end else begin
      max_c  = b_p1;
      min_c  = (r_p1 < g_p1) ? r_p1 : g_p1;
      d_c    = $signed({1'b0, r_p1}) - $signed({1'b0, g_p1});
      base_c = HUE_W'(HUE_BASE_B);
    end
    dlt_c = max_c - min_c;
  end

  logic [HNUM_W-1:0] hnum_p2;
  logic [SNUM_W-1:0] snum_p2;
  logic [VAL_W-1:0]  dlt_p2, max_p2;
  logic [HUE_W-1:0]  base_p2;
  logic              neg_p2, vld_p2;

  always_ff @(posedge clk) begin
    if (rst)
      vld_p2 <= 1'b0;
    else if (ce)
      vld_p2 <= vld_p1;
  end

  always_ff @(posedge clk) begin
    if (ce) begin
      hnum_p2 <= HNUM_W'(HUE_SECTOR) * HNUM_W'(mag8(d_c));
      snum_p2 <= SNUM_W'(SAT_MAX) * SNUM_W'(dlt_c);
      dlt_p2  <= dlt_c;
      max_p2  <= max_c;
      base_p2 <= base_c;
      neg_p2  <= d_c[8];
    end
  end

  // S3..S9: hue and saturation dividers with matching side lane
  logic              hvld_p9, svld_p9, vld_p9;
  logic [DQ_W-1:0]   hq_p9, sq_p9;
  logic [AUX_W-1:0]  aux_p [DQ_W];

  div_pipe #(.NUM_W(HNUM_W), .DEN_W(VAL_W), .Q_W(DQ_W)) u_hue_div (
    .clk(clk), .rst(rst), .ce(ce), .in_vld(vld_p2),
    .num(hnum_p2), .den(dlt_p2), .out_vld(hvld_p9), .quo(hq_p9)
  );

  div_pipe #(.NUM_W(SNUM_W), .DEN_W(VAL_W), .Q_W(DQ_W)) u_sat_div (
    .clk(clk), .rst(rst), .ce(ce), .in_vld(vld_p2),
    .num(snum_p2), .den(max_p2), .out_vld(svld_p9), .quo(sq_p9)
  );

  always_ff @(posedge clk) begin
    if (ce) begin
      aux_p[0] <= {base_p2, neg_p2, max_p2, (dlt_p2 == '0)};
      for (int k = 1; k < DQ_W; k++)
        aux_p[k] <= aux_p[k-1];
    end
  end

  // S9 -> S10: hue wrap, zero-divisor overrides, field pack
  logic [HUE_W-1:0]  base_p9;
  logic              neg_p9, dz_p9, en_p9;
  logic [VAL_W-1:0]  max_p9;
  logic [23:0]       rgb_p9, hsv_c;
  logic [12:0]       row_p9, col_p9;
  logic [SB_W-1:0]   sb_p9;

  assign vld_p9 = hvld_p9 & svld_p9;
  assign {base_p9, neg_p9, max_p9, dz_p9} = aux_p[DQ_W-1];
  assign en_p9  = side_p[LATENCY-2][SIDE_W-1];
  assign rgb_p9 = side_p[LATENCY-2][RGB_LO +: 24];
  assign row_p9 = side_p[LATENCY-2][ROW_LO +: 13];
  assign col_p9 = side_p[LATENCY-2][COL_LO +: 13];
  assign sb_p9  = side_p[LATENCY-2][SB_W-1:0];

  always_comb begin
    hsv_c = '0;
    hsv_c[HUE_HI:HUE_LO] = dz_p9 ? '0 : hue_fold(base_p9, neg_p9, hq_p9);
    hsv_c[SAT_HI:SAT_LO] = (max_p9 == '0) ? '0 : SAT_W'(sq_p9);
    hsv_c[VAL_HI:VAL_LO] = max_p9;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      pixel_out <= '0;
      row_out   <= '0;
      col_out   <= '0;
      pass_thru <= '0;
    end else if (ce) begin
      out_valid <= vld_p9;
      pixel_out <= en_p9 ? hsv_c : rgb_p9;
      row_out   <= row_p9;
      col_out   <= col_p9;
      pass_thru <= sb_p9;
    end
  end
endmodule

// File: tb/tb_rgb2hsv_pipe.sv
// Bench for rgb2hsv_pipe: directed colour cases, reset/ce/bypass behaviour and a random stream vs a reference model.
module tb_rgb2hsv_pipe;
  localparam int SB_W = 24;
  localparam int LAT  = 10;

  logic            clk = 1'b0;
  logic            rst, ce, hsv_en, in_valid;
  logic [12:0]     row, col;
  logic [23:0]     pixel_in;
  logic [SB_W-1:0] pass_in;
  logic            out_valid;
  logic [12:0]     row_out, col_out;
  logic [23:0]     pixel_out;
  logic [SB_W-1:0] pass_thru;

  typedef struct packed {
    logic            v;
    logic [23:0]     px;
    logic [12:0]     rw;
    logic [12:0]     cl;
    logic [SB_W-1:0] sb;
  } exp_t;

  exp_t pipe_q[$];
  exp_t cur;
  logic cmp_data = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  rgb2hsv_pipe #(.SB_W(SB_W)) dut (
    .clk(clk), .rst(rst), .ce(ce), .hsv_en(hsv_en), .in_valid(in_valid),
    .row(row), .col(col), .pixel_in(pixel_in), .pass_in(pass_in),
    .out_valid(out_valid), .row_out(row_out), .col_out(col_out),
    .pixel_out(pixel_out), .pass_thru(pass_thru)
  );

  // Straight HSV definition with signed integer arithmetic.
  function automatic logic [23:0] ref_hsv(input logic [23:0] px);
    int r, g, b, mx, mn, dl, h, s;
    r = int'(px[23:16]);
    g = int'(px[15:8]);
    b = int'(px[7:0]);
    mx = (r > g) ? r : g;
    mx = (mx > b) ? mx : b;
    mn = (r < g) ? r : g;
    mn = (mn < b) ? mn : b;
    dl = mx - mn;
    if (dl == 0)      h = 0;
    else if (mx == r) h = 60 * (g - b) / dl;
    else if (mx == g) h = 120 + 60 * (b - r) / dl;
    else              h = 240 + 60 * (r - g) / dl;
    if (h < 0) h = h + 360;
    s = (mx == 0) ? 0 : 100 * dl / mx;
    return {h[8:0], s[6:0], mx[7:0]};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input logic r, input logic c, input logic e, input logic v,
                      input logic [23:0] px, input logic [12:0] rw, input logic [12:0] cl,
                      input logic [SB_W-1:0] sb);
    exp_t n;
    rst = r; ce = c; hsv_en = e; in_valid = v;
    pixel_in = px; row = rw; col = cl; pass_in = sb;
    @(posedge clk);
    #1;
    if (r) begin
      pipe_q.delete();
      cur = '0;
      cmp_data = 1'b1;
    end else if (c) begin
      n.v  = v;
      n.px = e ? ref_hsv(px) : px;
      n.rw = rw;
      n.cl = cl;
      n.sb = sb;
      pipe_q.push_back(n);
      if (pipe_q.size() == LAT) begin
        cur = pipe_q.pop_front();
        cmp_data = 1'b1;
      end else begin
        cur.v = 1'b0;
        cmp_data = 1'b0;
      end
    end
    chk("out_valid", 64'(out_valid), 64'(cur.v));
    if (cmp_data) begin
      chk("pixel_out", 64'(pixel_out), 64'(cur.px));
      chk("row_out",   64'(row_out),   64'(cur.rw));
      chk("col_out",   64'(col_out),   64'(cur.cl));
      chk("pass_thru", 64'(pass_thru), 64'(cur.sb));
    end
  endtask

  task automatic directed(input string tag, input logic en, input logic [23:0] px,
                          input logic [23:0] want);
    tick(1'b0, 1'b1, en, 1'b1, px, 13'd7, 13'd9, 24'hA5C3E1);
    repeat (LAT - 1) tick(1'b0, 1'b1, 1'b1, 1'b0, 24'h0, 13'd0, 13'd0, '0);
    chk({tag, "_valid"}, 64'(out_valid), 64'(1));
    chk({tag, "_pix"},   64'(pixel_out), 64'(want));
    chk({tag, "_nox"},   64'($isunknown({out_valid, pixel_out, row_out, col_out})), 64'(0));
  endtask

  initial begin
    logic            c, v, e, did_rst;
    logic [23:0]     px;
    int              sent;

    tick(1'b1, 1'b1, 1'b1, 1'b0, 24'h0, 13'd0, 13'd0, '0);
    chk("reset_valid", 64'(out_valid), 64'(0));
    chk("reset_pix",   64'(pixel_out), 64'(0));

    directed("red",   1'b1, 24'hFF0000, {9'd0,   7'd100, 8'd255});
    directed("green", 1'b1, 24'h00FF00, {9'd120, 7'd100, 8'd255});
    directed("blue",  1'b1, 24'h0000FF, {9'd240, 7'd100, 8'd255});
    directed("g200",  1'b1, 24'h00C800, {9'd120, 7'd100, 8'd200});
    directed("neg_d", 1'b1, 24'hFF0080, {9'd330, 7'd100, 8'd255});
    directed("mixed", 1'b1, 24'h64C896, {9'd150, 7'd50,  8'd200});
    directed("gray",  1'b1, 24'h808080, 24'h000080);
    directed("black", 1'b1, 24'h000000, 24'h000000);
    directed("bypass", 1'b0, 24'h123456, 24'h123456);

    // reset with ce low still clears the outputs, then a pixel counts 10 ce cycles
    tick(1'b0, 1'b1, 1'b1, 1'b1, 24'h00FF00, 13'd1, 13'd2, 24'h1);
    tick(1'b1, 1'b0, 1'b1, 1'b1, 24'h00FF00, 13'd1, 13'd2, 24'h1);
    chk("rst_ce0_valid", 64'(out_valid), 64'(0));
    chk("rst_ce0_row",   64'(row_out),   64'(0));
    tick(1'b0, 1'b1, 1'b1, 1'b1, 24'hFF0000, 13'd33, 13'd44, 24'h55);
    repeat (4) tick(1'b0, 1'b1, 1'b1, 1'b0, 24'h0, 13'd0, 13'd0, '0);
    repeat (3) tick(1'b0, 1'b0, 1'b1, 1'b0, 24'h0, 13'd0, 13'd0, '0);
    repeat (4) tick(1'b0, 1'b1, 1'b1, 1'b0, 24'h0, 13'd0, 13'd0, '0);
    chk("post_rst_early", 64'(out_valid), 64'(0));
    tick(1'b0, 1'b1, 1'b1, 1'b0, 24'h0, 13'd0, 13'd0, '0);
    chk("post_rst_valid", 64'(out_valid), 64'(1));
    chk("post_rst_pix",   64'(pixel_out), 64'({9'd0, 7'd100, 8'd255}));
    chk("post_rst_row",   64'(row_out),   64'(33));

    sent = 0;
    did_rst = 1'b0;
    while (sent < 1000) begin
      c  = ($urandom_range(0, 7) != 0);
      v  = ($urandom_range(0, 3) != 0);
      e  = ($urandom_range(0, 9) != 0);
      px = 24'($urandom);
      if ($urandom_range(0, 7) == 0) px[15:8] = px[23:16];
      if ($urandom_range(0, 7) == 0) px[7:0]  = px[15:8];
      if ($urandom_range(0, 15) == 0) px = 24'h0;
      if (sent == 500 && !did_rst) begin
        tick(1'b1, c, e, v, px, 13'($urandom), 13'($urandom), SB_W'($urandom));
        did_rst = 1'b1;
      end else begin
        tick(1'b0, c, e, v, px, 13'($urandom), 13'($urandom), SB_W'($urandom));
        if (c && v) sent++;
      end
    end
    repeat (LAT) tick(1'b0, 1'b1, 1'b1, 1'b0, 24'h0, 13'd0, 13'd0, '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
